// File: rtl/voice_allocator.sv
// Purpose : allocates decoded MIDI note/CC events to VOICES synth voices (channel filter,
//           oldest/quietest steal, CC64 sustain, CC120/123 all-off, age-ranked reuse).
// Latency : note events VOICES+1 clocks accept-to-update capture; sustain/all-off flush VOICES clocks.
// Backpressure: ev_ready only in IDLE; update stream has no backpressure (one-cycle strobes).
// Ports   : CLOCK_50/reset_reg_N clock and async active-low reset; cfg_* channel/omni/steal mode;
//           voice_free envelope-idle flags; ev_* event handshake and fields; upd_* per-voice
//           update strobe and payload; keys_on per-voice gate; active_keys = popcount(keys_on).
module voice_allocator #(
  parameter int VOICES     = 8,
  parameter int V_WIDTH    = 3,
  parameter bit SUSTAIN_EN = 1'b1
) (
  input  logic               CLOCK_50,
  input  logic               reset_reg_N,
  input  logic [3:0]         cfg_chan,
  input  logic               cfg_omni,
  input  logic               cfg_steal_mode,
  input  logic [VOICES-1:0]  voice_free,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic [1:0]         ev_type,
  input  logic [3:0]         ev_chan,
  input  logic [6:0]         ev_d1,
  input  logic [6:0]         ev_d2,
  output logic               upd_valid,
  output logic [V_WIDTH-1:0] upd_voice,
  output logic               upd_gate,
  output logic [7:0]         upd_key,
  output logic [6:0]         upd_vel,
  output logic               upd_steal,
  output logic [VOICES-1:0]  keys_on,
  output logic [V_WIDTH:0]   active_keys
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_FLUSH} state_t;
  state_t state, state_nxt;

  logic [V_WIDTH-1:0] idx;
  logic               ev_on, pedal, flush_all;
  logic [6:0]         ev_key, ev_vel;
  logic [7:0]         key_r  [VOICES];
  logic [6:0]         vel_r  [VOICES];
  logic [V_WIDTH-1:0] rank_r [VOICES];
  logic [VOICES-1:0]  sus;

  // Running candidates collected during the scan, one voice per clock.
  logic               hit_vld, free_vld, rel_vld, stl_vld;
  logic [V_WIDTH-1:0] hit_idx, free_idx, rel_idx, stl_idx;
  logic [V_WIDTH-1:0] rel_rank, stl_rank;
  logic [6:0]         stl_vel;

  logic               chan_ok, idx_last, flush_hit, match, stl_better;
  logic               cur_on, cur_sus;
  logic [7:0]         cur_key;
  logic [6:0]         cur_vel;
  logic [V_WIDTH-1:0] cur_rank;
  logic               start_scan, start_flush, flush_all_nxt, pedal_set, pedal_clr;
  logic               cm_on, cm_off, cm_sus;
  logic [V_WIDTH-1:0] sel;

  assign chan_ok   = cfg_omni || (ev_chan == cfg_chan);
  assign idx_last  = (idx == V_WIDTH'(VOICES - 1));
  assign cur_on    = keys_on[idx];
  assign cur_sus   = sus[idx];
  assign cur_key   = key_r[idx];
  assign cur_vel   = vel_r[idx];
  assign cur_rank  = rank_r[idx];
  assign flush_hit = flush_all ? keys_on[idx] : sus[idx];
  // Note-on retriggers any holder of the key; note-off only releases a non-sustained holder.
  assign match     = cur_on && (cur_key == {1'b0, ev_key}) && (ev_on || !cur_sus);
  // Larger rank = older. Quietest mode breaks velocity ties towards the oldest voice.
  assign stl_better = !stl_vld ||
                      (cfg_steal_mode ? ((cur_vel < stl_vel) ||
                                         ((cur_vel == stl_vel) && (cur_rank > stl_rank)))
                                      : (cur_rank > stl_rank));

  always_comb begin
    active_keys = '0;
    for (int i = 0; i < VOICES; i++) active_keys = active_keys + (V_WIDTH+1)'(keys_on[i]);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) state <= S_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ev_ready = 1'b0;
    upd_valid = 1'b0;
    upd_voice = '0;
    upd_gate = 1'b0;
    upd_key = 8'hFF;
    upd_vel = '0;
    upd_steal = 1'b0;
    start_scan = 1'b0;
    start_flush = 1'b0;
    flush_all_nxt = 1'b0;
    pedal_set = 1'b0;
    pedal_clr = 1'b0;
    cm_on = 1'b0;
    cm_off = 1'b0;
    cm_sus = 1'b0;
    sel = hit_idx;
    case (state)
      S_IDLE: begin
        ev_ready = 1'b1;
        if (ev_valid && chan_ok) begin
          case (ev_type)
            2'b00, 2'b01: begin
              start_scan = 1'b1;
              state_nxt = S_SCAN;
            end
            2'b10: begin
              if (ev_d1 == 7'd64) begin
                if (SUSTAIN_EN) begin
                  if (ev_d2[6]) pedal_set = 1'b1;
                  else begin
                    pedal_clr = 1'b1;
                    if (|sus) begin
                      start_flush = 1'b1;
                      state_nxt = S_FLUSH;
                    end
                  end
                end
              end else if (ev_d1 == 7'd120 || ev_d1 == 7'd123) begin
                pedal_clr = 1'b1;
                start_flush = 1'b1;
                flush_all_nxt = 1'b1;
                state_nxt = S_FLUSH;
              end
            end
            default: ;
          endcase
        end
      end
      S_SCAN: if (idx_last) state_nxt = S_COMMIT;
      S_COMMIT: begin
        state_nxt = S_IDLE;
        if (ev_on) begin
          if (hit_vld)       sel = hit_idx;
          else if (free_vld) sel = free_idx;
          else if (rel_vld)  sel = rel_idx;
          else               sel = stl_idx;
          cm_on = 1'b1;
          upd_valid = 1'b1;
          upd_voice = sel;
          upd_gate = 1'b1;
          upd_key = {1'b0, ev_key};
          upd_vel = ev_vel;
          upd_steal = !hit_vld && !free_vld && !rel_vld;
        end else if (hit_vld) begin
          if (pedal) cm_sus = 1'b1;
          else begin
            cm_off = 1'b1;
            upd_valid = 1'b1;
            upd_voice = hit_idx;
            upd_vel = ev_vel;
          end
        end
      end
      S_FLUSH: begin
        if (flush_hit) begin
          upd_valid = 1'b1;
          upd_voice = idx;
        end
        if (idx_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      idx <= '0;
      ev_on <= 1'b0;
      ev_key <= '0;
      ev_vel <= '0;
      pedal <= 1'b0;
      flush_all <= 1'b0;
      keys_on <= '0;
      sus <= '0;
      hit_vld <= 1'b0;
      free_vld <= 1'b0;
      rel_vld <= 1'b0;
      stl_vld <= 1'b0;
      hit_idx <= '0;
      free_idx <= '0;
      rel_idx <= '0;
      stl_idx <= '0;
      rel_rank <= '0;
      stl_rank <= '0;
      stl_vel <= '0;
      for (int i = 0; i < VOICES; i++) begin
        key_r[i] <= 8'hFF;
        vel_r[i] <= '0;
        rank_r[i] <= V_WIDTH'(i);
      end
    end else begin
      if (start_scan || start_flush) idx <= '0;
      else if (state == S_SCAN || state == S_FLUSH) idx <= idx + 1'b1;
      if (pedal_set) pedal <= 1'b1;
      if (pedal_clr) pedal <= 1'b0;
      if (start_flush) flush_all <= flush_all_nxt;
      if (start_scan) begin
        // Note-on with zero velocity is a note-off with release velocity 0.
        ev_on <= (ev_type == 2'b01) && (ev_d2 != 7'd0);
        ev_key <= ev_d1;
        ev_vel <= ev_d2;
        hit_vld <= 1'b0;
        free_vld <= 1'b0;
        rel_vld <= 1'b0;
        stl_vld <= 1'b0;
      end
      if (state == S_SCAN) begin
        if (match && !hit_vld) begin
          hit_vld <= 1'b1;
          hit_idx <= idx;
        end
        if (!cur_on && voice_free[idx] && !free_vld) begin
          free_vld <= 1'b1;
          free_idx <= idx;
        end
        if (!cur_on && (!rel_vld || cur_rank > rel_rank)) begin
          rel_vld <= 1'b1;
          rel_idx <= idx;
          rel_rank <= cur_rank;
        end
        if (cur_on && stl_better) begin
          stl_vld <= 1'b1;
          stl_idx <= idx;
          stl_rank <= cur_rank;
          stl_vel <= cur_vel;
        end
      end
      if (cm_on) begin
        keys_on[sel] <= 1'b1;
        sus[sel] <= 1'b0;
        key_r[sel] <= {1'b0, ev_key};
        vel_r[sel] <= ev_vel;
        // Move chosen voice to the front; only younger voices age, so ranks stay a permutation.
        for (int i = 0; i < VOICES; i++) begin
          if (V_WIDTH'(i) == sel) rank_r[i] <= '0;
          else if (rank_r[i] < rank_r[sel]) rank_r[i] <= rank_r[i] + 1'b1;
        end
      end
      if (cm_off) begin
        keys_on[hit_idx] <= 1'b0;
        key_r[hit_idx] <= 8'hFF;
      end
      if (cm_sus) sus[hit_idx] <= 1'b1;
      if (state == S_FLUSH && flush_hit) begin
        keys_on[idx] <= 1'b0;
        sus[idx] <= 1'b0;
        key_r[idx] <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Purpose : directed self-checking bench for voice_allocator (VOICES=8).
// Latency : checks note updates captured VOICES+1 clocks after accept, flushes VOICES clocks.
// Backpressure: events are offered only while ev_ready is high; updates logged every cycle.
module tb_voice_allocator;
  localparam int VOICES = 8;
  localparam int VW = 3;

  logic CLOCK_50 = 1'b0;
  logic reset_reg_N = 1'b0;
  logic [3:0] cfg_chan = 4'd0;
  logic cfg_omni = 1'b1;
  logic cfg_steal_mode = 1'b0;
  logic [VOICES-1:0] voice_free = '1;
  logic ev_valid = 1'b0;
  logic ev_ready;
  logic [1:0] ev_type = 2'b00;
  logic [3:0] ev_chan = 4'd0;
  logic [6:0] ev_d1 = 7'd0;
  logic [6:0] ev_d2 = 7'd0;
  logic upd_valid;
  logic [VW-1:0] upd_voice;
  logic upd_gate;
  logic [7:0] upd_key;
  logic [6:0] upd_vel;
  logic upd_steal;
  logic [VOICES-1:0] keys_on;
  logic [VW:0] active_keys;

  voice_allocator #(.VOICES(VOICES), .V_WIDTH(VW), .SUSTAIN_EN(1'b1)) dut (
    .CLOCK_50(CLOCK_50), .reset_reg_N(reset_reg_N),
    .cfg_chan(cfg_chan), .cfg_omni(cfg_omni), .cfg_steal_mode(cfg_steal_mode),
    .voice_free(voice_free),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type), .ev_chan(ev_chan),
    .ev_d1(ev_d1), .ev_d2(ev_d2),
    .upd_valid(upd_valid), .upd_voice(upd_voice), .upd_gate(upd_gate), .upd_key(upd_key),
    .upd_vel(upd_vel), .upd_steal(upd_steal), .keys_on(keys_on), .active_keys(active_keys)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {int voice; int gate; int key; int vel; int steal; int cap;} upd_t;
  upd_t q[$];
  upd_t rec;
  // cap = the clock edge that captures this update
  always @(negedge CLOCK_50) begin
    if (reset_reg_N && upd_valid) begin
      rec.voice = int'(upd_voice);
      rec.gate = int'(upd_gate);
      rec.key = int'(upd_key);
      rec.vel = int'(upd_vel);
      rec.steal = int'(upd_steal);
      rec.cap = cyc + 1;
      q.push_back(rec);
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int acc_cyc = 0;
  int n;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // All tasks start and end #1 after a rising edge.
  task automatic send(input logic [1:0] t, input logic [3:0] ch, input logic [6:0] d1,
                      input logic [6:0] d2);
    int w = 0;
    while (!ev_ready && w < 50) begin
      @(posedge CLOCK_50); #1;
      w++;
    end
    chk("ev_ready_before_send", int'(ev_ready), 1);
    ev_valid = 1'b1;
    ev_type = t;
    ev_chan = ch;
    ev_d1 = d1;
    ev_d2 = d2;
    @(posedge CLOCK_50); #1;
    acc_cyc = cyc;
    ev_valid = 1'b0;
  endtask

  task automatic settle(output int cnt);
    cnt = 0;
    while (!ev_ready && cnt < 40) begin
      @(posedge CLOCK_50); #1;
      cnt++;
    end
    if (cnt >= 40) chk("settle_timeout", int'(ev_ready), 1);
  endtask

  task automatic play(input logic [1:0] t, input logic [3:0] ch, input logic [6:0] d1,
                      input logic [6:0] d2, output int cnt);
    send(t, ch, d1, d2);
    settle(cnt);
  endtask

  task automatic do_reset();
    reset_reg_N = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset_reg_N = 1'b1;
    q.delete();
  endtask

  task automatic chk_upd(input string tag, input int i, input int v, input int g, input int k,
                         input int vl, input int s);
    if (q.size() > i) begin
      chk({tag, "_voice"}, q[i].voice, v);
      chk({tag, "_gate"}, q[i].gate, g);
      chk({tag, "_key"}, q[i].key, k);
      chk({tag, "_vel"}, q[i].vel, vl);
      chk({tag, "_steal"}, q[i].steal, s);
    end else begin
      chk({tag, "_present"}, q.size(), i + 1);
    end
  endtask

  initial begin
    // T1: reset values, then a first note-on
    do_reset();
    chk("rst_ev_ready", int'(ev_ready), 1);
    chk("rst_upd_valid", int'(upd_valid), 0);
    chk("rst_upd_key", int'(upd_key), 255);
    chk("rst_upd_voice", int'(upd_voice), 0);
    chk("rst_upd_vel", int'(upd_vel), 0);
    chk("rst_keys_on", int'(keys_on), 0);
    chk("rst_active", int'(active_keys), 0);
    play(2'b01, 4'd0, 7'd60, 7'd100, n);
    chk("t1_busy_clks", n, VOICES + 1);
    chk("t1_nupd", q.size(), 1);
    chk_upd("t1", 0, 0, 1, 60, 100, 0);
    if (q.size() > 0) chk("t1_latency", q[0].cap - acc_cyc, VOICES + 1);
    chk("t1_active", int'(active_keys), 1);

    // T2: fill all voices, then steal oldest
    do_reset();
    for (int i = 0; i < VOICES; i++) play(2'b01, 4'd0, 7'(60 + i), 7'd100, n);
    chk("t2_nupd", q.size(), VOICES);
    for (int i = 0; i < VOICES; i++)
      if (q.size() > i) chk("t2_alloc_voice", q[i].voice, i);
    chk("t2_keys_on", int'(keys_on), 255);
    q.delete();
    play(2'b01, 4'd0, 7'd70, 7'd100, n);
    chk("t2_nupd_steal", q.size(), 1);
    chk_upd("t2_steal", 0, 0, 1, 70, 100, 1);
    chk("t2_active", int'(active_keys), VOICES);

    // T3: quietest steal
    cfg_steal_mode = 1'b1;
    do_reset();
    for (int i = 0; i < VOICES; i++) play(2'b01, 4'd0, 7'(60 + i), (i == 1) ? 7'd10 : 7'd90, n);
    q.delete();
    play(2'b01, 4'd0, 7'd70, 7'd55, n);
    chk_upd("t3_steal", 0, 1, 1, 70, 55, 1);
    chk("t3_active", int'(active_keys), VOICES);
    cfg_steal_mode = 1'b0;

    // T4: sustain pedal holds a released note, pedal-up flushes it
    do_reset();
    play(2'b01, 4'd0, 7'd60, 7'd100, n);
    q.delete();
    play(2'b10, 4'd0, 7'd64, 7'd127, n);
    chk("t4_cc64_on_clks", n, 0);
    play(2'b00, 4'd0, 7'd60, 7'd40, n);
    chk("t4_sus_nupd", q.size(), 0);
    chk("t4_sus_gate", int'(keys_on), 1);
    chk("t4_sus_active", int'(active_keys), 1);
    play(2'b10, 4'd0, 7'd64, 7'd0, n);
    chk("t4_flush_clks", n, VOICES);
    chk("t4_flush_nupd", q.size(), 1);
    chk_upd("t4_flush", 0, 0, 0, 255, 0, 0);
    chk("t4_active", int'(active_keys), 0);

    // T5: channel filter, zero-velocity note-on, retrigger, release via vel 0
    cfg_omni = 1'b0;
    cfg_chan = 4'd3;
    do_reset();
    play(2'b01, 4'd5, 7'd60, 7'd100, n);
    chk("t5_wrongchan_clks", n, 0);
    chk("t5_wrongchan_nupd", q.size(), 0);
    play(2'b01, 4'd3, 7'd61, 7'd0, n);
    chk("t5_vel0_nupd", q.size(), 0);
    chk("t5_vel0_active", int'(active_keys), 0);
    play(2'b01, 4'd3, 7'd61, 7'd50, n);
    play(2'b01, 4'd3, 7'd61, 7'd70, n);
    chk("t5_retrig_nupd", q.size(), 2);
    chk_upd("t5_retrig", 1, 0, 1, 61, 70, 0);
    chk("t5_retrig_active", int'(active_keys), 1);
    q.delete();
    play(2'b01, 4'd3, 7'd61, 7'd0, n);
    chk_upd("t5_off", 0, 0, 0, 255, 0, 0);
    chk("t5_off_active", int'(active_keys), 0);
    cfg_omni = 1'b1;
    cfg_chan = 4'd0;

    // T7: no free envelopes -> reuse oldest released voice
    voice_free = '0;
    do_reset();
    play(2'b01, 4'd0, 7'd60, 7'd100, n);
    play(2'b01, 4'd0, 7'd61, 7'd100, n);
    chk_upd("t7_first", 0, 7, 1, 60, 100, 0);
    chk_upd("t7_second", 1, 6, 1, 61, 100, 0);
    voice_free = '1;

    // T6: all-notes-off flush, then reset during a scan
    do_reset();
    for (int i = 0; i < 4; i++) play(2'b01, 4'd0, 7'(60 + i), 7'd100, n);
    q.delete();
    play(2'b10, 4'd0, 7'd123, 7'd0, n);
    chk("t6_flush_clks", n, VOICES);
    chk("t6_flush_nupd", q.size(), 4);
    for (int i = 0; i < 4; i++) chk_upd("t6_flush", i, i, 0, 255, 0, 0);
    chk("t6_active", int'(active_keys), 0);
    q.delete();
    send(2'b01, 4'd0, 7'd64, 7'd100);
    repeat (3) @(posedge CLOCK_50);
    #1;
    reset_reg_N = 1'b0;
    #1;
    chk("t6_rst_ev_ready", int'(ev_ready), 1);
    chk("t6_rst_upd_valid", int'(upd_valid), 0);
    chk("t6_rst_upd_key", int'(upd_key), 255);
    chk("t6_rst_keys_on", int'(keys_on), 0);
    @(posedge CLOCK_50); #1;
    reset_reg_N = 1'b1;
    repeat (12) @(posedge CLOCK_50);
    #1;
    chk("t6_lost_nupd", q.size(), 0);
    chk("t6_lost_active", int'(active_keys), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
